pea_pipe: RTL and testbench

- Pipelined, back-pressured successor to the combinational PE array of the SC polar decoder.
- Processes one stage-update command per transaction: a stream of NUM_BEATS vectors, each LANES wide, evaluated under one op (f or g).
- Sits between the LLR memory read port and its write-back port, so one LANES-wide array serves any stage length N/2 = LANES × beats.
- Adds symmetric saturation, a 2-stage pipeline with valid/ready flow control and a command FSM with done signalling.

---
 rtl/polar_pkg.sv | 34 +++
 rtl/pe_lane_pipe.sv | 82 ++++++++
 rtl/pea_pipe.sv | 144 ++++++++++++++
 tb/tb_pea_pipe.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
// Shared definitions for the pipelined polar-decoder PE array: op codes, FSM
// states and symmetric LLR saturation helpers.
package polar_pkg;

    localparam logic OP_F = 1'b0;
    localparam logic OP_G = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Clamp an integer to the symmetric range [-(2^(w-1)-1), 2^(w-1)-1].
    function automatic int sat_llr(input int val, input int unsigned w);
        int smax;
        smax = int'((32'd1 << (w - 1)) - 32'd1);
        if (val > smax) begin
            return smax;
        end
        if (val < -smax) begin
            return -smax;
        end
        return val;
    endfunction

    function automatic int abs_sat(input int val, input int unsigned w);
        int v;
        v = sat_llr(val, w);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/pe_lane_pipe.sv
// One PE lane: two-stage f/g datapath. Stage enables come from the array
// controller so every lane stalls in lock-step.
module pe_lane_pipe
    import polar_pkg::*;
#(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en1,
    input  logic         en2,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ps,
    output logic [W-1:0] llr_out
);

    localparam int unsigned MW = W - 1;
    localparam int unsigned SW = W + 1;

    logic [MW-1:0] abs_a_d, abs_a_q;
    logic [MW-1:0] abs_b_d, abs_b_q;
    logic          sgn_d, sgn_q;
    logic [SW-1:0] sum_d, sum_q;
    logic [W-1:0]  res_d, res_q;

    int            a_c;
    int            b_c;
    int            g_val;
    logic [MW-1:0] mag;

    // S1: fold -2^(W-1) onto -SMAX, then form magnitudes and the wide sum/difference.
    always_comb begin
        a_c     = sat_llr(int'($signed(a)), W);
        b_c     = sat_llr(int'($signed(b)), W);
        abs_a_d = MW'(abs_sat(a_c, W));
        abs_b_d = MW'(abs_sat(b_c, W));
        sgn_d   = a[W-1] ^ b[W-1];
        sum_d   = SW'(ps ? (b_c - a_c) : (b_c + a_c));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abs_a_q <= '0;
            abs_b_q <= '0;
            sgn_q   <= 1'b0;
            sum_q   <= '0;
        end else if (en1) begin
            abs_a_q <= abs_a_d;
            abs_b_q <= abs_b_d;
            sgn_q   <= sgn_d;
            sum_q   <= sum_d;
        end
    end

    // S2: min-sum select for f (zero magnitude never gets a sign), clamp for g.
    always_comb begin
        mag   = (abs_a_q < abs_b_q) ? abs_a_q : abs_b_q;
        g_val = sat_llr(int'($signed(sum_q)), W);
        if (op == OP_G) begin
            res_d = W'(g_val);
        end else if (mag == '0) begin
            res_d = '0;
        end else if (sgn_q) begin
            res_d = W'(0) - {1'b0, mag};
        end else begin
            res_d = {1'b0, mag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else if (en2) begin
            res_q <= res_d;
        end
    end

    assign llr_out = res_q;

endmodule

// File: rtl/pea_pipe.sv
// Pipelined, back-pressured PE array: LANES lanes of pe_lane_pipe under a
// command FSM that streams num_beats beats per f/g stage update.
module pea_pipe
    import polar_pkg::*;
#(
    parameter int unsigned INTER_LLR_WIDTH = 6,
    parameter int unsigned LANES           = 64,
    parameter int unsigned BEAT_CNT_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               op,
    input  logic [BEAT_CNT_WIDTH-1:0]          num_beats,
    output logic                               busy,
    output logic                               done,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [INTER_LLR_WIDTH*LANES-1:0]   llr_a,
    input  logic [INTER_LLR_WIDTH*LANES-1:0]   llr_b,
    input  logic [LANES-1:0]                   ps,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [INTER_LLR_WIDTH*LANES-1:0]   llr_out,
    output logic                               out_last
);

    localparam int unsigned W = INTER_LLR_WIDTH;

    state_e                    state_d, state_q;
    logic                      op_d, op_q;
    logic [BEAT_CNT_WIDTH-1:0] nb_d, nb_q;
    logic [BEAT_CNT_WIDTH-1:0] beats_in_d, beats_in_q;
    logic                      s1_valid_d, s1_valid_q;
    logic                      s1_last_d, s1_last_q;
    logic                      s2_valid_d, s2_valid_q;
    logic                      s2_last_d, s2_last_q;

    logic adv1;
    logic adv2;
    logic accept;
    logic last_in;

    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = (state_q == RUN) && (beats_in_q < nb_q) && adv1;
    assign accept   = in_valid && in_ready;
    assign last_in  = (beats_in_q == (nb_q - BEAT_CNT_WIDTH'(1)));

    // Valid/last ride alongside the lane data; a held stage keeps its contents.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        if (adv1) begin
            s1_valid_d = accept;
            s1_last_d  = accept && last_in;
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        nb_d       = nb_q;
        beats_in_d = beats_in_q;
        done       = 1'b0;
        if (accept) begin
            beats_in_d = beats_in_q + BEAT_CNT_WIDTH'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = op;
                    nb_d       = num_beats;
                    beats_in_d = '0;
                    state_d    = (num_beats == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && last_in) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (s2_valid_q && s2_last_q && out_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_F;
            nb_q       <= '0;
            beats_in_q <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            nb_q       <= nb_d;
            beats_in_q <= beats_in_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = s2_valid_q;
    assign out_last  = s2_valid_q && s2_last_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_lane_pipe #(
            .W(W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en1     (adv1),
            .en2     (adv2),
            .op      (op_q),
            .a       (llr_a[i*W +: W]),
            .b       (llr_b[i*W +: W]),
            .ps      (ps[i]),
            .llr_out (llr_out[i*W +: W])
        );
    end

endmodule

// File: tb/tb_pea_pipe.sv
// Self-checking bench for pea_pipe: directed vector table, randomized streams
// against a behavioural model, and hand-written corner sequences.
module tb_pea_pipe;

    localparam int W     = 6;
    localparam int LANES = 4;
    localparam int BCW   = 8;
    localparam int LW    = W * LANES;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           op = 1'b0;
    logic [BCW-1:0] num_beats = '0;
    logic           busy;
    logic           done;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [LW-1:0]  llr_a = '0;
    logic [LW-1:0]  llr_b = '0;
    logic [LANES-1:0] ps = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [LW-1:0]  llr_out;
    logic           out_last;

    pea_pipe #(
        .INTER_LLR_WIDTH(W),
        .LANES          (LANES),
        .BEAT_CNT_WIDTH (BCW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .num_beats (num_beats),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .llr_a     (llr_a),
        .llr_b     (llr_b),
        .ps        (ps),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .llr_out   (llr_out),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int sx(input logic [W-1:0] c);
        return int'($signed(c));
    endfunction

    function automatic int ref_lane(input logic o, input int a, input int b, input logic p);
        int smax, m, s, ma, mb;
        smax = 31;
        if (a < -smax) a = -smax;
        if (b < -smax) b = -smax;
        if (o == 1'b0) begin
            ma = (a < 0) ? -a : a;
            mb = (b < 0) ? -b : b;
            m  = (ma < mb) ? ma : mb;
            if (m == 0) return 0;
            return ((a < 0) != (b < 0)) ? -m : m;
        end
        s = p ? (b - a) : (b + a);
        if (s > smax) s = smax;
        if (s < -smax) s = -smax;
        return s;
    endfunction

    function automatic logic [LW-1:0] ref_beat(input logic o, input logic [LW-1:0] a,
                                               input logic [LW-1:0] b, input logic [LANES-1:0] p);
        logic [LW-1:0] r;
        for (int i = 0; i < LANES; i++) begin
            r[i*W +: W] = W'(ref_lane(o, sx(a[i*W +: W]), sx(b[i*W +: W]), p[i]));
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
        logic [LW-1:0] r;
        r[0*W +: W] = W'(l0);
        r[1*W +: W] = W'(l1);
        r[2*W +: W] = W'(l2);
        r[3*W +: W] = W'(l3);
        return r;
    endfunction

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic start_cmd(input logic o, input logic [BCW-1:0] n);
        start     = 1'b1;
        op        = o;
        num_beats = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_stream(input logic cop, input int n, input int bp_pct, input int vld_pct,
                              input bit nobubble, input bit inject_start, input string tag);
        logic [LW-1:0] q[$];
        logic [LW-1:0] exp_d;
        logic [LW-1:0] prev_llr;
        logic          prev_last;
        logic          prev_stall;
        int acc, emitted, cyc, first_acc, first_out, last_out;
        acc = 0; emitted = 0; cyc = 0; first_acc = 0; first_out = 0; last_out = 0;
        prev_stall = 1'b0; prev_llr = '0; prev_last = 1'b0;
        start_cmd(cop, BCW'(n));
        while (emitted < n && cyc < 3000) begin
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, out_valid, 1);
                chk({tag, "_hold_data"}, llr_out, prev_llr);
                chk({tag, "_hold_last"}, out_last, prev_last);
            end
            out_ready = (bp_pct == 0) ? 1'b1 : ($urandom_range(99) >= bp_pct);
            start     = 1'b0;
            if (inject_start && cyc == 3) begin
                start     = 1'b1;
                op        = ~cop;
                num_beats = 8'd9;
            end
            if (acc < n && $urandom_range(99) < vld_pct) begin
                in_valid = 1'b1;
                llr_a    = LW'($urandom);
                llr_b    = LW'($urandom);
                ps       = LANES'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if ((acc - emitted) == 2 && !out_ready) chk({tag, "_full_in_ready"}, in_ready, 0);
            if (acc == n) chk({tag, "_in_ready_after_last"}, in_ready, 0);
            if (inject_start && cyc == 3) chk({tag, "_busy_on_restart"}, busy, 1);
            if (in_valid && in_ready) begin
                q.push_back(ref_beat(cop, llr_a, llr_b, ps));
                if (acc == 0) first_acc = cyc;
                acc++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk({tag, "_spurious_out"}, out_valid, 0);
                end else begin
                    exp_d = q.pop_front();
                    chk({tag, "_data"}, llr_out, exp_d);
                    chk({tag, "_last"}, out_last, (emitted == n - 1));
                end
                if (emitted == 0) first_out = cyc;
                last_out = cyc;
                emitted++;
            end
            prev_stall = out_valid && !out_ready;
            prev_llr   = llr_out;
            prev_last  = out_last;
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        if (emitted < n) begin
            chk({tag, "_timeout_beats"}, emitted, n);
        end else begin
            chk({tag, "_done"}, done, 1);
        end
        if (nobubble) begin
            chk({tag, "_no_bubbles"}, last_out - first_out, n - 1);
            chk({tag, "_latency"}, first_out - first_acc, 2);
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle_after"}, busy, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string            name;
        logic             o;
        logic [LW-1:0]    a;
        logic [LW-1:0]    b;
        logic [LANES-1:0] p;
        logic [LW-1:0]    e;
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int dcount;
        int acc;
        vecs[0] = '{name: "f_basic", o: 1'b0, a: pack4(5, -7, 0, -32), b: pack4(-3, -9, 12, 4),
                    p: 4'b0000, e: pack4(-3, 7, 0, -4)};
        vecs[1] = '{name: "g_sat", o: 1'b1, a: pack4(20, 20, -32, 3), b: pack4(20, -20, -5, 10),
                    p: 4'b1010, e: pack4(31, -31, -31, 7)};
        vecs[2] = '{name: "f_edge", o: 1'b0, a: pack4(31, -1, 0, -32), b: pack4(-31, -1, -5, -32),
                    p: 4'b0000, e: pack4(-31, 1, 0, 31)};
        vecs[3] = '{name: "g_edge", o: 1'b1, a: pack4(0, -32, 10, -31), b: pack4(0, 31, -4, -32),
                    p: 4'b1011, e: pack4(0, 31, 6, 0)};

        // Reset state
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_llr_out", llr_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single-beat commands: latency, out_last, done timing
        for (int i = 0; i < 4; i++) begin
            start_cmd(vecs[i].o, 8'd1);
            llr_a = vecs[i].a; llr_b = vecs[i].b; ps = vecs[i].p;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk({vecs[i].name, "_in_ready"}, in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            chk({vecs[i].name, "_lat1_valid"}, out_valid, 0);
            @(negedge clk);
            chk({vecs[i].name, "_lat2_valid"}, out_valid, 1);
            chk({vecs[i].name, "_data"}, llr_out, vecs[i].e);
            chk({vecs[i].name, "_last"}, out_last, 1);
            chk({vecs[i].name, "_early_done"}, done, 0);
            @(negedge clk);
            chk({vecs[i].name, "_done"}, done, 1);
            chk({vecs[i].name, "_drained"}, out_valid, 0);
            @(negedge clk);
            chk({vecs[i].name, "_done_off"}, done, 0);
            chk({vecs[i].name, "_idle"}, busy, 0);
        end

        // Streaming without back-pressure
        run_stream(1'b0, 16, 0, 100, 1'b1, 1'b0, "stream_f");
        run_stream(1'b1, 16, 0, 100, 1'b1, 1'b0, "stream_g");
        // Random back-pressure and input gaps
        run_stream(1'b0, 24, 50, 70, 1'b0, 1'b0, "bp_f");
        run_stream(1'b1, 24, 50, 100, 1'b0, 1'b0, "bp_g");
        run_stream(1'b1, 12, 85, 100, 1'b0, 1'b0, "heavy_bp");
        // Start pulse while busy must be ignored
        run_stream(1'b1, 6, 0, 60, 1'b0, 1'b1, "restart_ignored");

        // Empty command
        start_cmd(1'b0, 8'd0);
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("empty_in_ready", in_ready, 0);
            if (done) dcount++;
            @(negedge clk);
        end
        chk("empty_done_count", dcount, 1);
        chk("empty_idle", busy, 0);

        // Reset in the middle of an 8-beat command
        start_cmd(1'b0, 8'd8);
        out_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 20 && acc < 3; c++) begin
            in_valid = 1'b1;
            llr_a = LW'($urandom) | LW'(24'h041041);
            llr_b = LW'($urandom) | LW'(24'h041041);
            ps = LANES'($urandom);
            #1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_rst_accepted", acc, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_llr_out", llr_out, 0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", dcount, 0);
        run_stream(1'b0, 5, 30, 80, 1'b0, 1'b0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
